// File: rtl/tx_bit_serializer_if.sv
// Byte-stream handshake from the TX packet builders into the bit serializer.
// Master drives the byte, slave answers with ready.
interface tx_bit_serializer_if;
  logic       sop;
  logic       eop;
  logic       valid;
  logic       ready;
  logic [7:0] data;

  modport master (
    output sop, eop, valid, data,
    input  ready
  );

  modport slave (
    input  sop, eop, valid, data,
    output ready
  );
endinterface

// File: rtl/tx_bit_serializer.sv
// USB TX serializer: SYNC, LSB-first data with bit stuffing, then SE0/SE0/J.
// One bit period lasts BIT_DIV clocks; outputs change only on bit_en cycles.
module tx_bit_serializer #(
  parameter int         BIT_DIV   = 4,
  parameter logic [7:0] SYNC_BYTE = 8'h80
) (
  input  logic              clk,
  input  logic              rst,
  tx_bit_serializer_if.slave tx_to,
  output logic              tx_bit,
  output logic              tx_se0,
  output logic              tx_bit_en,
  output logic              tx_active,
  output logic              tx_underrun,
  output logic              tx_drop
);

  localparam int DW = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
  localparam logic [DW-1:0] DMAX = DW'(BIT_DIV - 1);
  localparam logic [DW-1:0] DPRE = (BIT_DIV > 1) ? DW'(BIT_DIV - 2) : '0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SYNC,
    S_DATA,
    S_EOP
  } state_t;

  state_t        r_state;
  logic [DW-1:0] r_div;
  logic [2:0]    r_idx;
  logic [2:0]    r_ones;
  logic [1:0]    r_eopc;
  logic          r_stuff;
  logic          r_staged;
  logic [7:0]    r_hdata;
  logic          r_heop;
  logic          r_hsop;
  logic          r_hfull;
  logic [7:0]    r_shreg;
  logic          r_ceop;
  logic          r_bit;
  logic          r_se0;
  logic          r_en;
  logic          r_act;
  logic          r_ur;
  logic          r_drop;

  logic       w_ready;
  logic       w_acc;
  logic       w_end;
  logic       w_pre;
  logic       w_last;
  logic [2:0] w_idx_n;
  logic [2:0] w_ones_n;
  logic [7:0] w_nb;
  logic       w_nb_eop;
  logic       w_more;
  logic       w_stage;

  assign w_ready  = !r_hfull && (r_state != S_EOP);
  assign w_acc    = tx_to.valid && w_ready;
  assign w_end    = r_act && (r_div == DMAX);
  assign w_pre    = (BIT_DIV > 1) && r_act && (r_div == DPRE);
  assign w_last   = (r_idx == 3'd7);
  assign w_idx_n  = r_idx + 3'd1;
  assign w_ones_n = r_bit ? r_ones + 3'd1 : 3'd0;
  assign w_nb     = r_staged ? r_shreg : r_hdata;
  assign w_nb_eop = r_staged ? r_ceop : r_heop;
  assign w_more   = r_staged || (r_hfull && !r_ceop);

  // Pull the next byte into the shifter one clock before the period ends,
  // so the upstream sees ready during the final clock of that period.
  assign w_stage = w_pre && r_hfull && !r_staged && !r_stuff && w_last &&
                   ((r_state == S_SYNC) ||
                    ((r_state == S_DATA) && !r_ceop));

  assign tx_to.ready = w_ready;
  assign tx_bit      = r_bit;
  assign tx_se0      = r_se0;
  assign tx_bit_en   = r_en;
  assign tx_active   = r_act;
  assign tx_underrun = r_ur;
  assign tx_drop     = r_drop;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_div    <= '0;
      r_idx    <= '0;
      r_ones   <= '0;
      r_eopc   <= '0;
      r_stuff  <= 1'b0;
      r_staged <= 1'b0;
      r_hdata  <= '0;
      r_heop   <= 1'b0;
      r_hsop   <= 1'b0;
      r_hfull  <= 1'b0;
      r_shreg  <= '0;
      r_ceop   <= 1'b0;
      r_bit    <= 1'b1;
      r_se0    <= 1'b0;
      r_en     <= 1'b0;
      r_act    <= 1'b0;
      r_ur     <= 1'b0;
      r_drop   <= 1'b0;
    end else begin
      r_en   <= 1'b0;
      r_ur   <= 1'b0;
      r_drop <= 1'b0;
      if (w_acc) begin
        if ((r_state == S_IDLE) && !tx_to.sop) begin
          r_drop <= 1'b1;
        end else begin
          r_hdata <= tx_to.data;
          r_heop  <= tx_to.eop;
          r_hsop  <= tx_to.sop;
          r_hfull <= 1'b1;
        end
      end
      if (r_act) r_div <= w_end ? '0 : r_div + DW'(1);
      if (w_stage) begin
        r_shreg  <= r_hdata;
        r_ceop   <= r_heop;
        r_hfull  <= 1'b0;
        r_staged <= 1'b1;
      end
      unique case (r_state)
        S_IDLE: begin
          if ((w_acc && tx_to.sop) || (r_hfull && r_hsop)) begin
            r_state  <= S_SYNC;
            r_act    <= 1'b1;
            r_en     <= 1'b1;
            r_div    <= '0;
            r_bit    <= SYNC_BYTE[0];
            r_se0    <= 1'b0;
            r_idx    <= '0;
            r_ones   <= '0;
            r_stuff  <= 1'b0;
            r_staged <= 1'b0;
          end else if (r_hfull) begin
            r_hfull <= 1'b0;
            r_drop  <= 1'b1;
          end
        end
        S_SYNC: begin
          if (w_end) begin
            r_en   <= 1'b1;
            r_ones <= w_ones_n;
            if (!w_last) begin
              r_idx <= w_idx_n;
              r_bit <= SYNC_BYTE[w_idx_n];
            end else begin
              r_state  <= S_DATA;
              r_idx    <= '0;
              r_bit    <= w_nb[0];
              r_shreg  <= w_nb;
              r_ceop   <= w_nb_eop;
              r_staged <= 1'b0;
              if (!r_staged) r_hfull <= 1'b0;
            end
          end
        end
        S_DATA: begin
          if (w_end) begin
            r_en <= 1'b1;
            if (w_ones_n == 3'd6) begin
              // Stuffed zero: the data position holds still.
              r_stuff <= 1'b1;
              r_bit   <= 1'b0;
              r_ones  <= '0;
            end else if (!w_last) begin
              r_stuff <= 1'b0;
              r_ones  <= w_ones_n;
              r_idx   <= w_idx_n;
              r_bit   <= r_shreg[w_idx_n];
            end else if (w_more) begin
              r_stuff  <= 1'b0;
              r_ones   <= w_ones_n;
              r_idx    <= '0;
              r_bit    <= w_nb[0];
              r_shreg  <= w_nb;
              r_ceop   <= w_nb_eop;
              r_staged <= 1'b0;
              if (!r_staged) r_hfull <= 1'b0;
            end else begin
              r_state <= S_EOP;
              r_stuff <= 1'b0;
              r_ones  <= '0;
              r_eopc  <= '0;
              r_se0   <= 1'b1;
              r_bit   <= 1'b0;
              r_ur    <= !r_ceop;
            end
          end
        end
        S_EOP: begin
          if (w_end) begin
            r_eopc <= r_eopc + 2'd1;
            if (r_eopc == 2'd2) begin
              r_state <= S_IDLE;
              r_act   <= 1'b0;
              r_div   <= '0;
              r_eopc  <= '0;
            end else begin
              r_en <= 1'b1;
              if (r_eopc == 2'd1) begin
                r_se0 <= 1'b0;
                r_bit <= 1'b1;
              end
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_bit_serializer.sv
// Directed bench for tx_bit_serializer at BIT_DIV=1 and BIT_DIV=4.
// Bit periods are logged as '0', '1' or 'S' (SE0) and compared to hand sequences.
module tb_tx_bit_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       v1 = 1'b0;
  logic       v4 = 1'b0;
  logic       sop = 1'b0;
  logic       eop = 1'b0;
  logic [7:0] dat = 8'h00;

  always #5 clk = ~clk;

  tx_bit_serializer_if if1 ();
  tx_bit_serializer_if if4 ();

  assign if1.valid = v1;
  assign if1.sop   = sop;
  assign if1.eop   = eop;
  assign if1.data  = dat;
  assign if4.valid = v4;
  assign if4.sop   = sop;
  assign if4.eop   = eop;
  assign if4.data  = dat;

  logic b1, z1, e1, a1, u1, d1;
  logic b4, z4, e4, a4, u4, d4;

  tx_bit_serializer #(.BIT_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .tx_to(if1),
    .tx_bit(b1), .tx_se0(z1), .tx_bit_en(e1),
    .tx_active(a1), .tx_underrun(u1), .tx_drop(d1)
  );

  tx_bit_serializer #(.BIT_DIV(4)) dut4 (
    .clk(clk), .rst(rst), .tx_to(if4),
    .tx_bit(b4), .tx_se0(z4), .tx_bit_en(e4),
    .tx_active(a4), .tx_underrun(u4), .tx_drop(d4)
  );

  int    cyc = 0;
  string s1 = "";
  string s4 = "";
  int    en1q[$];
  int    en4q[$];
  int    ur4q[$];
  int    dr1q[$];
  int    ac1 = 0;
  int    ac4 = 0;
  int    n_chk = 0;
  int    n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic string sym(input logic z, input logic b);
    return z ? "S" : (b ? "1" : "0");
  endfunction

  always @(negedge clk) begin
    if (e1) begin
      s1 = {s1, sym(z1, b1)};
      en1q.push_back(cyc);
    end
    if (a1) ac1++;
    if (d1) dr1q.push_back(cyc);
    if (e4) begin
      s4 = {s4, sym(z4, b4)};
      en4q.push_back(cyc);
    end
    if (a4) ac4++;
    if (u4) ur4q.push_back(cyc);
  end

  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [127:0] pk(input string s);
    logic [127:0] v = '0;
    for (int i = 0; i < s.len(); i++)
      v = {v[125:0], (s[i] == "S") ? 2'd2 : ((s[i] == "1") ? 2'd1 : 2'd0)};
    return v;
  endfunction

  task automatic chk_seq(input string tag, input int sel, input int base,
                         input string exp);
    string s = (sel == 4) ? s4 : s1;
    string g = s.substr(base, s.len() - 1);
    check({tag, "_seq"}, pk(g), pk(exp));
    check({tag, "_len"}, g.len(), exp.len());
  endtask

  // Caller is just past a rising edge; returns just past the accepting edge.
  task automatic send(input int sel, input logic [7:0] d, input logic s,
                      input logic e, output int acc);
    bit got = 1'b0;
    sop = s;
    eop = e;
    dat = d;
    if (sel == 4) v4 = 1'b1;
    else v1 = 1'b1;
    acc = -1;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      if ((sel == 4) ? if4.ready : if1.ready) begin
        acc = cyc;
        got = 1'b1;
      end
    end
    if (!got) check("send_timeout", 0, 1);
    @(posedge clk);
    #1;
    v1 = 1'b0;
    v4 = 1'b0;
  endtask

  task automatic wait_idle(input int sel);
    bit done = 1'b0;
    for (int i = 0; i < 1000 && !done; i++) begin
      @(negedge clk);
      done = (sel == 4) ? !a4 : !a1;
    end
    if (!done) check("idle_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  int b, k, ac, t0, t1, t2, gaps;

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_dut1", {if1.ready, b1, z1, e1, a1, u1, d1}, 7'b1100000);
    check("rst_dut4", {if4.ready, b4, z4, e4, a4, u4, d4}, 7'b1100000);
    @(posedge clk);
    #1;

    b = s1.len();
    k = en1q.size();
    ac = ac1;
    send(1, 8'hD2, 1'b1, 1'b1, t0);
    wait_idle(1);
    chk_seq("d2", 1, b, "0000000101001011SS1");
    check("d2_en", en1q.size() - k, 19);
    check("d2_act", ac1 - ac, 19);
    check("d2_lat", en1q[k] - t0, 1);

    b = s1.len();
    k = en1q.size();
    send(1, 8'hFF, 1'b1, 1'b0, t0);
    send(1, 8'hFF, 1'b0, 1'b1, t1);
    wait_idle(1);
    chk_seq("ff", 1, b, "00000001111110111111011111SS1");
    check("ff_en", en1q.size() - k, 29);

    b = s4.len();
    k = en4q.size();
    ac = ac4;
    send(4, 8'hE1, 1'b1, 1'b0, t0);
    send(4, 8'h00, 1'b0, 1'b0, t1);
    send(4, 8'h10, 1'b0, 1'b1, t2);
    wait_idle(4);
    chk_seq("tok", 4, b, "00000001100001110000000000001000SS1");
    check("tok_acc2", t1 - t0, 32);
    check("tok_acc3", t2 - t0, 64);
    check("tok_lat", en4q[k] - t0, 1);
    check("tok_en", en4q.size() - k, 35);
    check("tok_act", ac4 - ac, 140);
    gaps = 0;
    for (int i = k + 1; i < en4q.size(); i++)
      if (en4q[i] - en4q[i-1] != 4) gaps++;
    check("tok_gap", gaps, 0);

    b = s4.len();
    k = ur4q.size();
    send(4, 8'hC3, 1'b1, 1'b0, t0);
    wait_idle(4);
    chk_seq("ur", 4, b, "0000000111000011SS1");
    check("ur_cnt", ur4q.size() - k, 1);
    check("ur_when", ur4q[k] - t0, 65);
    check("ur_idle", {a4, if4.ready}, 2'b01);

    k = dr1q.size();
    ac = ac1;
    send(1, 8'h5A, 1'b0, 1'b0, t0);
    repeat (4) @(posedge clk);
    #1;
    check("drop_cnt", dr1q.size() - k, 1);
    check("drop_when", dr1q[k] - t0, 1);
    check("drop_act", ac1 - ac, 0);
    b = s1.len();
    send(1, 8'hD2, 1'b1, 1'b1, t0);
    wait_idle(1);
    chk_seq("after_drop", 1, b, "0000000101001011SS1");

    send(4, 8'hE1, 1'b1, 1'b0, t0);
    send(4, 8'h00, 1'b0, 1'b1, t1);
    while (cyc < t0 + 75) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst", {a4, z4, b4, if4.ready}, 4'b0011);
    @(posedge clk);
    #1;
    b = s4.len();
    ac = ac4;
    send(4, 8'hD2, 1'b1, 1'b1, t0);
    wait_idle(4);
    chk_seq("fresh", 4, b, "0000000101001011SS1");
    check("fresh_act", ac4 - ac, 76);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
